spi_byte_rx: RTL and testbench
==============================

Name: spi_byte_rx

Overview:
- Receive-side deserializer for the team's single-wire framed serial link.
- Consumes the serial data line and frame-enable line produced by the SPI transmit stage. Reassembles 8-bit bytes and presents them to the downstream decrypt/hash logic through a valid/acknowledge holding register.
- Runs on the same system clock as the transmitter. Each serial slot lasts exactly one clk cycle.

Parameters:
- DATA_W, 8: bits per byte frame.
- SLOT_CHECK, 1: when 1, marker and trailer slot values are checked and mismatches flagged as frame errors; when 0, those slots are ignored.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- spi_in  input  1  serial data line.
- spi_en  input  1  frame enable, active-high; high for the whole frame.
- rd_ack  input  1  downstream consumed data_out; sampled only while data_valid=1.
- data_out  output  DATA_W  last committed byte.
- data_valid  output  1  data_out holds an unconsumed byte.
- frame_err  output  1  one-cycle pulse on a bad or aborted frame.
- overrun  output  1  sticky; a completed byte was dropped because data_valid was still 1.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Line format:
  - Each bit occupies 3 consecutive slots: marker (1), data bit, trailer (0).
  - Bits are sent LSB first, DATA_W bits per frame, 3*DATA_W slots total (24 for DATA_W=8).
- Input registering: spi_in and spi_en are registered once (spi_in_r, spi_en_r). The FSM acts only on the registered values.
- Reset (async, immediate): state=IDLE, bit counter=0, shift register=0, data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0, input registers=0.
- FSM states: IDLE, DATA, TRAIL, MARK.
  - IDLE: if spi_en_r=1 and spi_in_r=1, treat as marker of bit 0 and go to DATA. Otherwise stay. spi_en_r=1 with spi_in_r=0 in IDLE is ignored (line idle/garbage), with no error.
  - DATA: shift register bit [bitcnt] <= spi_in_r; go to TRAIL.
  - TRAIL:
    - If SLOT_CHECK=1 and spi_in_r=1: pulse frame_err and go to IDLE, discarding the partial byte.
    - Else if bitcnt=DATA_W-1: commit the byte, bitcnt<=0, go to IDLE.
    - Else: bitcnt<=bitcnt+1, go to MARK.
  - MARK: if SLOT_CHECK=1 and spi_in_r=0, pulse frame_err and go to IDLE. Else go to DATA.
- Abort: in DATA, TRAIL or MARK, spi_en_r=0 overrides all other transitions. Pulse frame_err, go to IDLE, bitcnt<=0, no commit.
- Commit:
  - If data_valid=0: data_out<=assembled byte, data_valid<=1.
  - If data_valid=1 and no rd_ack on the same cycle: drop the new byte, set overrun, data_out unchanged.
  - If data_valid=1 and rd_ack=1 on the same cycle: accept the new byte; data_valid stays 1; no overrun.
- Handshake:
  - rd_ack with data_valid=1 and no commit: data_valid<=0 on the next edge.
  - rd_ack with data_valid=0 is ignored.
  - overrun clears only on rd_ack or rst.
- Latency: data_valid rises on the second rising edge after the bit-(DATA_W-1) trailer slot is presented on the pins.
- Back-to-back frames: the marker of the next frame may immediately follow the final trailer, with zero idle slots.
- frame_err is exactly one cycle wide per event.
- busy=1 whenever state≠IDLE.

Test Plan:
- Frame 0xA5, spi_en high for 24 slots, rd_ack low -> data_out=0xA5; data_valid rises 2 edges after the last trailer slot; frame_err=0, overrun=0.
- Two back-to-back frames 0x3C then 0xF0 with rd_ack pulsed 1 cycle after the first data_valid -> data_out=0x3C, then 0xF0; no frame_err, no overrun.
- Frames 0x11 then 0x22, no rd_ack -> data_out stays 0x11; overrun=1 after the second frame. rd_ack -> data_valid=0 and overrun=0 on the next edge.
- Frame 0x55 with spi_en dropped after slot 10 -> one-cycle frame_err pulse, busy=0, data_valid stays 0. A following valid 0x0F frame is received correctly.
- Frame 0x80 with bit-3 trailer forced to 1, SLOT_CHECK=1 -> frame_err pulse, no commit. Same stimulus with SLOT_CHECK=0 -> data_out=0x80, no error.
- rst asserted mid-frame (slot 13) and released -> all outputs 0 asynchronously. A subsequent 0xC3 frame gives data_out=0xC3.

Source files
------------

// File: rtl/spi_byte_rx_if.sv
// Bundle of serial-line, handshake and status signals for spi_byte_rx.
// The master side drives the line and the acknowledge; the slave side is the receiver.
interface spi_byte_rx_if #(
   parameter int DATA_W = 8
);
   logic              spi_in;
   logic              spi_en;
   logic              rd_ack;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              frame_err;
   logic              overrun;
   logic              busy;

   modport master (
      output spi_in, spi_en, rd_ack,
      input  data_out, data_valid, frame_err, overrun, busy
   );

   modport slave (
      input  spi_in, spi_en, rd_ack,
      output data_out, data_valid, frame_err, overrun, busy
   );
endinterface

// File: rtl/spi_byte_rx.sv
// Deserializer for the framed serial link: each bit is marker(1)/data/trailer(0),
// LSB first. Bytes land in a valid/ack holding register with sticky overrun.
module spi_byte_rx #(
   parameter int DATA_W     = 8,
   parameter bit SLOT_CHECK = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   spi_byte_rx_if.slave bus
);
   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, DATA, TRAIL, MARK} state_t;

   state_t            state, state_nx;
   logic              spi_in_r, spi_en_r;
   logic [CW-1:0]     bitcnt;
   logic [DATA_W-1:0] shreg;
   logic              shift_en, cnt_inc, cnt_clr, commit, err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      shift_en = 1'b0;
      cnt_inc  = 1'b0;
      cnt_clr  = 1'b0;
      commit   = 1'b0;
      err      = 1'b0;
      case (state)
         IDLE: begin
            // Enable with a low line is treated as idle noise, not an error.
            if (spi_en_r && spi_in_r) state_nx = DATA;
         end
         DATA: begin
            shift_en = 1'b1;
            state_nx = TRAIL;
         end
         TRAIL: begin
            if (SLOT_CHECK && spi_in_r) begin
               err      = 1'b1;
               cnt_clr  = 1'b1;
               state_nx = IDLE;
            end else if (bitcnt == LAST) begin
               commit   = 1'b1;
               cnt_clr  = 1'b1;
               state_nx = IDLE;
            end else begin
               cnt_inc  = 1'b1;
               state_nx = MARK;
            end
         end
         MARK: begin
            if (SLOT_CHECK && !spi_in_r) begin
               err      = 1'b1;
               cnt_clr  = 1'b1;
               state_nx = IDLE;
            end else begin
               state_nx = DATA;
            end
         end
         default: state_nx = IDLE;
      endcase
      // Losing enable mid-frame wins over every other transition.
      if (state != IDLE && !spi_en_r) begin
         state_nx = IDLE;
         err      = 1'b1;
         cnt_clr  = 1'b1;
         shift_en = 1'b0;
         cnt_inc  = 1'b0;
         commit   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spi_in_r       <= 1'b0;
         spi_en_r       <= 1'b0;
         bitcnt         <= '0;
         shreg          <= '0;
         bus.data_out   <= '0;
         bus.data_valid <= 1'b0;
         bus.frame_err  <= 1'b0;
         bus.overrun    <= 1'b0;
      end else begin
         spi_in_r      <= bus.spi_in;
         spi_en_r      <= bus.spi_en;
         bus.frame_err <= err;

         if (cnt_clr)      bitcnt <= '0;
         else if (cnt_inc) bitcnt <= bitcnt + CW'(1);

         if (shift_en) shreg[bitcnt] <= spi_in_r;

         // A commit landing on the same edge as an ack replaces the consumed byte.
         if (commit && (!bus.data_valid || bus.rd_ack)) begin
            bus.data_out   <= shreg;
            bus.data_valid <= 1'b1;
         end else if (bus.data_valid && bus.rd_ack) begin
            bus.data_valid <= 1'b0;
         end

         if (bus.data_valid && bus.rd_ack)  bus.overrun <= 1'b0;
         else if (commit && bus.data_valid) bus.overrun <= 1'b1;
      end
   end

   assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_spi_byte_rx.sv
// Directed bench for spi_byte_rx: a table of framed bytes plus hand sequences for
// back-to-back frames, ack coinciding with commit, and mid-frame reset.
module tb_spi_byte_rx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic spi_in = 1'b0, spi_en = 1'b0, rd_ack = 1'b0;
   int   checks = 0, errors = 0;
   int   ferr0 = 0, ferr1 = 0;

   always #5 clk = ~clk;

   spi_byte_rx_if #(.DATA_W(8)) bus0 ();
   spi_byte_rx_if #(.DATA_W(8)) bus1 ();

   assign bus0.spi_in = spi_in;
   assign bus0.spi_en = spi_en;
   assign bus0.rd_ack = rd_ack;
   assign bus1.spi_in = spi_in;
   assign bus1.spi_en = spi_en;
   assign bus1.rd_ack = rd_ack;

   spi_byte_rx #(.DATA_W(8), .SLOT_CHECK(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   spi_byte_rx #(.DATA_W(8), .SLOT_CHECK(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   // frame_err pulses, counted once per high cycle
   always @(posedge clk) begin
      if (bus0.frame_err) ferr0 <= ferr0 + 1;
      if (bus1.frame_err) ferr1 <= ferr1 + 1;
   end

   typedef struct {
      logic [7:0] d;
      int         drop;
      int         bad;
      bit         ack;
      bit         lat;
      logic [7:0] x_data;
      bit         x_dv;
      bit         x_ovr;
      int         x_err;
      logic [7:0] x1_data;
      bit         x1_dv;
      int         x1_err;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic slot(input logic en, input logic d);
      @(negedge clk);
      spi_en = en;
      spi_in = d;
   endtask

   // 24 slots; enable stays high through slot 'drop' (or all, if drop<0);
   // bit index 'bad' gets its trailer forced to 1.
   task automatic send_frame(input logic [7:0] b, input int drop, input int bad);
      for (int s = 0; s < 24; s++) begin
         logic en, v;
         en = (drop < 0) || (s <= drop);
         case (s % 3)
            0:       v = 1'b1;
            1:       v = b[s/3];
            default: v = (bad == s/3);
         endcase
         slot(en, en & v);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) slot(1'b0, 1'b0);
   endtask

   initial begin
      int e0, e1, seen;
      #200000;
      $display("FAIL watchdog: simulation did not finish, limit %0d", 200000);
      $fatal(1, "timeout");
   end

   initial begin
      int e0, e1, seen;
      //         d      drop bad ack lat  xdata dv ovr err  x1data dv1 err1
      tbl[0] = '{8'hA5, -1, -1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 0, 8'hA5, 1'b1, 0};
      tbl[1] = '{8'h11, -1, -1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 0, 8'h11, 1'b1, 0};
      tbl[2] = '{8'h22, -1, -1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 0, 8'h11, 1'b1, 0};
      tbl[3] = '{8'h55, 10, -1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1, 8'h11, 1'b0, 1};
      tbl[4] = '{8'h0F, -1, -1, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, 0, 8'h0F, 1'b1, 0};
      tbl[5] = '{8'h80, -1,  3, 1'b1, 1'b0, 8'h0F, 1'b0, 1'b0, 2, 8'h80, 1'b1, 0};

      repeat (3) @(negedge clk);
      chk("rst_data_out", 32'(bus0.data_out), 32'h0);
      chk("rst_data_valid", 32'(bus0.data_valid), 32'h0);
      chk("rst_overrun", 32'(bus0.overrun), 32'h0);
      chk("rst_busy", 32'(bus0.busy), 32'h0);
      chk("rst_frame_err", 32'(bus0.frame_err), 32'h0);
      chk("rst_dut1_valid", 32'(bus1.data_valid), 32'h0);
      rst = 1'b0;
      idle(2);

      for (int i = 0; i < 6; i++) begin
         if (tbl[i].ack) begin
            slot(1'b0, 1'b0);
            rd_ack = 1'b1;
            slot(1'b0, 1'b0);
            rd_ack = 1'b0;
         end
         e0 = ferr0;
         e1 = ferr1;
         send_frame(tbl[i].d, tbl[i].drop, tbl[i].bad);
         slot(1'b0, 1'b0);
         if (tbl[i].lat) chk($sformatf("v%0d_valid_early", i), 32'(bus0.data_valid), 32'h0);
         slot(1'b0, 1'b0);
         if (tbl[i].lat) chk($sformatf("v%0d_valid_latency", i), 32'(bus0.data_valid), 32'h1);
         idle(2);
         chk($sformatf("v%0d_data_out", i), 32'(bus0.data_out), 32'(tbl[i].x_data));
         chk($sformatf("v%0d_data_valid", i), 32'(bus0.data_valid), 32'(tbl[i].x_dv));
         chk($sformatf("v%0d_overrun", i), 32'(bus0.overrun), 32'(tbl[i].x_ovr));
         chk($sformatf("v%0d_err_pulses", i), 32'(ferr0 - e0), 32'(tbl[i].x_err));
         chk($sformatf("v%0d_err_low", i), 32'(bus0.frame_err), 32'h0);
         chk($sformatf("v%0d_busy", i), 32'(bus0.busy), 32'h0);
         chk($sformatf("v%0d_nochk_data", i), 32'(bus1.data_out), 32'(tbl[i].x1_data));
         chk($sformatf("v%0d_nochk_valid", i), 32'(bus1.data_valid), 32'(tbl[i].x1_dv));
         chk($sformatf("v%0d_nochk_err", i), 32'(ferr1 - e1), 32'(tbl[i].x1_err));
      end

      // Reset in the middle of a frame while a byte is held valid.
      send_frame(8'h99, -1, -1);
      idle(4);
      chk("pre_rst_valid", 32'(bus0.data_valid), 32'h1);
      for (int s = 0; s < 13; s++) slot(1'b1, (s % 3 == 0) ? 1'b1 : 1'b0);
      @(negedge clk);
      chk("pre_rst_busy", 32'(bus0.busy), 32'h1);
      #2 rst = 1'b1;
      spi_en = 1'b0;
      spi_in = 1'b0;
      #1;
      chk("async_rst_data_out", 32'(bus0.data_out), 32'h0);
      chk("async_rst_valid", 32'(bus0.data_valid), 32'h0);
      chk("async_rst_busy", 32'(bus0.busy), 32'h0);
      chk("async_rst_overrun", 32'(bus0.overrun), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      e0 = ferr0;
      send_frame(8'hC3, -1, -1);
      idle(4);
      chk("post_rst_data", 32'(bus0.data_out), 32'hC3);
      chk("post_rst_valid", 32'(bus0.data_valid), 32'h1);
      chk("post_rst_err", 32'(ferr0 - e0), 32'h0);
      slot(1'b0, 1'b0);
      rd_ack = 1'b1;
      slot(1'b0, 1'b0);
      rd_ack = 1'b0;
      chk("ack_clears_valid", 32'(bus0.data_valid), 32'h0);

      // Back-to-back frames; ack one cycle after the first byte shows up.
      e0 = ferr0;
      fork
         begin
            send_frame(8'h3C, -1, -1);
            send_frame(8'hF0, -1, -1);
            idle(4);
         end
         begin
            seen = 0;
            for (int n = 0; n < 60 && seen == 0; n++) begin
               @(negedge clk);
               if (bus0.data_valid) seen = 1;
            end
            chk("b2b_first_seen", 32'(seen), 32'h1);
            chk("b2b_first_data", 32'(bus0.data_out), 32'h3C);
            @(negedge clk);
            rd_ack = 1'b1;
            @(negedge clk);
            rd_ack = 1'b0;
         end
      join
      chk("b2b_second_data", 32'(bus0.data_out), 32'hF0);
      chk("b2b_second_valid", 32'(bus0.data_valid), 32'h1);
      chk("b2b_overrun", 32'(bus0.overrun), 32'h0);
      chk("b2b_err", 32'(ferr0 - e0), 32'h0);

      // Ack on the very edge of a commit: new byte taken, stays valid, no overrun.
      send_frame(8'h5A, -1, -1);
      slot(1'b0, 1'b0);
      rd_ack = 1'b1;
      slot(1'b0, 1'b0);
      rd_ack = 1'b0;
      chk("ack_commit_data", 32'(bus0.data_out), 32'h5A);
      chk("ack_commit_valid", 32'(bus0.data_valid), 32'h1);
      chk("ack_commit_overrun", 32'(bus0.overrun), 32'h0);
      idle(2);
      chk("ack_commit_hold", 32'(bus0.data_valid), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
